// File: rtl/ark_column_collector.sv
// ark_column_collector: AddRoundKey column collector for the AES encrypt datapath.
// Takes one MixColumns output column per cycle, XORs it with the matching round-key
// word and assembles NB columns into a 128-bit state presented on a valid/ready port.
// Optional feature macro: ARK_DOUBLE_BUF_EN (a second collect buffer lets the next state
// fill while the current one is held, giving one state per 4 cycles).
// Two banks are always present: the displayed bank drives state_out, the other bank
// is filled in the background, so state_out only changes when a new state is presented.

module ark_column_collector #(
  parameter int unsigned NB         = 4,
  parameter bit          KEY_SAMPLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              col_valid,
  output logic              col_ready,
  input  logic [31:0]       col_data,
  input  logic [32*NB-1:0]  round_key,
  input  logic              abort,
  output logic              state_valid,
  input  logic              state_ready,
  output logic [32*NB-1:0]  state_out
);

  localparam int unsigned W  = 32 * NB;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LastCol = CW'(NB - 1);

  // StHoldFull is only reachable with the double buffer: output held and alternate full
  typedef enum logic [1:0] {
    StCollect,
    StHold,
    StHoldFull
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_bank [2];
  logic            r_rd;
  logic [W-1:0]    r_key;

  logic            w_wr;
  logic            w_acc;
  logic            w_last;
  logic            w_hand;
  logic            w_swap;
  logic [31:0]     w_key_word;
  logic [31:0]     w_word;

  // The fill bank is always the one not being displayed
  assign w_wr   = ~r_rd;
  // abort wins over a column offered in the same cycle
  assign w_acc  = col_valid & col_ready & ~abort;
  assign w_last = w_acc & (r_cnt == LastCol);
  assign w_hand = state_valid & state_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StCollect;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; w_swap marks the cycle a completed bank becomes the displayed one
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    unique case (r_state)
      StCollect: begin
        if (w_last) begin
          w_state_nxt = StHold;
          w_swap      = 1'b1;
        end
      end
      StHold: begin
`ifdef ARK_DOUBLE_BUF_EN
        if (w_last && w_hand) begin
          // hand-off and completion together: stay valid, switch banks
          w_swap = 1'b1;
        end else if (w_last) begin
          w_state_nxt = StHoldFull;
        end else if (w_hand) begin
          w_state_nxt = StCollect;
        end
`else
        if (w_hand) begin
          w_state_nxt = StCollect;
        end
`endif
      end
      StHoldFull: begin
        if (w_hand) begin
          w_state_nxt = StHold;
          w_swap      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StCollect;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    state_valid = (r_state != StCollect);
`ifdef ARK_DOUBLE_BUF_EN
    col_ready   = (r_state != StHoldFull);
`else
    col_ready   = (r_state == StCollect);
`endif
    state_out   = r_bank[r_rd];
  end

  // Round-key word for the current slot; slot 0 always uses the live key
  always_comb begin
    w_key_word = '0;
    for (int i = 0; i < NB; i++) begin
      if (r_cnt == CW'(i)) begin
        if (KEY_SAMPLE && (i != 0)) begin
          w_key_word = r_key[W-1-32*i -: 32];
        end else begin
          w_key_word = round_key[W-1-32*i -: 32];
        end
      end
    end
    w_word = col_data ^ w_key_word;
  end

  // Column counter: wraps after the last column, cleared by abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (abort) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Round-key snapshot taken with the first column of each state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key <= '0;
    end else if (w_acc && (r_cnt == '0)) begin
      r_key <= round_key;
    end
  end

  // Fill the background bank and flip the display pointer on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_rd      <= 1'b0;
    end else begin
      if (w_acc) begin
        for (int b = 0; b < 2; b++) begin
          for (int i = 0; i < NB; i++) begin
            if ((w_wr == 1'(b)) && (r_cnt == CW'(i))) begin
              r_bank[b][W-1-32*i -: 32] <= w_word;
            end
          end
        end
      end
      if (w_swap) begin
        r_rd <= w_wr;
      end
    end
  end

endmodule

// File: tb/tb_ark_column_collector.sv
// Testbench for ark_column_collector: directed FIPS-197 vectors plus randomized traffic,
// checked by a scoreboard fed from a queue-based reference model.

module tb_ark_column_collector;

  localparam bit KS = 1'b1;
  localparam logic [127:0] FipsKey = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FipsOut = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
`ifdef ARK_DOUBLE_BUF_EN
  localparam int Spacing = 4;
`else
  localparam int Spacing = 5;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         col_valid = 1'b0;
  logic         col_ready;
  logic [31:0]  col_data = '0;
  logic [127:0] round_key = '0;
  logic         abort = 1'b0;
  logic         state_valid;
  logic         state_ready = 1'b0;
  logic [127:0] state_out;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [127:0] q[$];       // expected results, oldest first
  logic [31:0]  m_cols[$];  // model: keyed columns of the state being collected
  logic [127:0] m_key;      // model: key captured with the first column
  int           m_held = 0; // model: completed states inside the DUT
  int           hs_cyc[$];

  logic [31:0] fips_cols[4];

  ark_column_collector #(
    .NB        (4),
    .KEY_SAMPLE(KS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_data   (col_data),
    .round_key  (round_key),
    .abort      (abort),
    .state_valid(state_valid),
    .state_ready(state_ready),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] kw(input logic [127:0] k, input int i);
    return k[127-32*i -: 32];
  endfunction

  // Monitor: whenever a result is presented it must match the oldest expected one
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && state_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_state: got %h expected no result", state_out);
        end else begin
          chk("state_out", state_out, q[0]);
          if (state_ready) begin
            void'(q.pop_front());
            hs_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  // One clock cycle: drive, check handshake outputs, advance the model at the edge
  task automatic step(input logic v, input logic [31:0] d, input logic [127:0] k,
                      input logic ab, input logic sr, output logic acc);
    logic        rdy;
    logic        hand;
    logic [31:0] w;
    col_valid   = v;
    col_data    = d;
    round_key   = k;
    abort       = ab;
    state_ready = sr;
`ifdef ARK_DOUBLE_BUF_EN
    rdy = (m_held < 2);
`else
    rdy = (m_held == 0);
`endif
    @(negedge clk);
    chk("col_ready", 128'(col_ready), 128'(rdy));
    chk("state_valid", 128'(state_valid), 128'(m_held > 0));
    @(posedge clk);
    acc  = 1'b0;
    hand = (m_held > 0) && sr;
    if (ab) begin
      m_cols.delete();
    end else if (v && rdy) begin
      if (m_cols.size() == 0) m_key = k;
      w = d ^ kw((KS && m_cols.size() != 0) ? m_key : k, m_cols.size());
      m_cols.push_back(w);
      acc = 1'b1;
      if (m_cols.size() == 4) begin
        q.push_back({m_cols[0], m_cols[1], m_cols[2], m_cols[3]});
        m_cols.delete();
        m_held++;
      end
    end
    if (hand) m_held--;
    #1;
  endtask

  task automatic send_col(input logic [31:0] d, input logic [127:0] k, input logic sr);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(1'b1, d, k, 1'b0, sr, acc);
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic do_reset(input string nm);
    rst         = 1'b1;
    col_valid   = 1'b0;
    abort       = 1'b0;
    state_ready = 1'b0;
    @(posedge clk);
    m_cols.delete();
    q.delete();
    m_held = 0;
    #1;
    rst = 1'b0;
    chk({nm, "_valid"}, 128'(state_valid), 128'(0));
    chk({nm, "_out"}, state_out, 128'(0));
    chk({nm, "_ready"}, 128'(col_ready), 128'(1));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 128'h0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         acc;
    logic         v, ab, sr;
    logic [127:0] rk;

    fips_cols[0] = 32'h046681e5;
    fips_cols[1] = 32'he0cb199a;
    fips_cols[2] = 32'h48f8d37a;
    fips_cols[3] = 32'h2806264c;

    #1;
    do_reset("reset");

    // FIPS-197 round 1, held until backpressure release
    for (int i = 0; i < 4; i++) send_col(fips_cols[i], FipsKey, 1'b0);
    chk("fips_valid", 128'(state_valid), 128'(1));
    chk("fips_out", state_out, FipsOut);

    // Backpressure for 10 cycles with a column waiting
    for (int i = 0; i < 10; i++) step(1'b1, fips_cols[0], FipsKey, 1'b0, 1'b0, acc);
    send_col(fips_cols[0], FipsKey, 1'b1);
    for (int i = 1; i < 4; i++) send_col(fips_cols[i], FipsKey, 1'b0);
    chk("bp_out", state_out, FipsOut);

    // Key changes to all-ff after the first column
    send_col(fips_cols[0], FipsKey, 1'b1);
    for (int i = 1; i < 4; i++) send_col(fips_cols[i], {128{1'b1}}, 1'b0);
    chk("keysample_out", state_out, FipsOut);

    // Abort after two columns with a column offered in the same cycle
    step(1'b0, 32'h0, FipsKey, 1'b0, 1'b1, acc);
    rk = {$urandom, $urandom, $urandom, $urandom};
    send_col($urandom, rk, 1'b0);
    send_col($urandom, rk, 1'b0);
    step(1'b1, $urandom, rk, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) send_col($urandom, rk, 1'b0);
    chk("abort_valid", 128'(state_valid), 128'(1));

    // Reset with three columns collected, then again while holding
    step(1'b0, 32'h0, rk, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) send_col($urandom, rk, 1'b0);
    do_reset("rst_cnt3");
    for (int i = 0; i < 4; i++) send_col($urandom, rk, 1'b0);
    do_reset("rst_hold");

    // Back-to-back eight columns, consumer always ready
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) send_col($urandom, rk, 1'b1);
    idle(3);
    chk("b2b_count", 128'(hs_cyc.size()), 128'(2));
    if (hs_cyc.size() >= 2) chk("b2b_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'(Spacing));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) rk = {$urandom, $urandom, $urandom, $urandom};
      v  = ($urandom_range(0, 9) < 7);
      ab = ($urandom_range(0, 19) == 0);
      sr = ($urandom_range(0, 9) < 6);
      step(v, $urandom, rk, ab, sr, acc);
    end
    idle(12);
    chk("drain_empty", 128'(q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
